game_sequencer: RTL

Frame-rate game controller for the rocket/asteroid display pipeline. It owns the game state machine (idle, play, hit, game over) and schedules the pool of asteroid sprite slots. It spawns a slot at an LFSR-supplied x position on a fixed frame cadence, retires slots that leave the screen, latches rocket/asteroid pixel collisions per frame, and maintains lives and score. It sits beside `videoGen` and is clocked by the pixel clock, with a one-cycle frame strobe; it replaces vsync-clocked enable logic.

---
 rtl/galaga_pkg.sv | 16 +
 rtl/game_sequencer_slot_allocator.sv | 15 +
 rtl/game_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/galaga_pkg.sv
// Shared types and screen constants for the rocket/asteroid game blocks.
// Pure declarations: no logic, no latency, no flow control.
package galaga_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } game_state_t;

   localparam int SCREEN_W       = 640;
   localparam int SCREEN_H       = 480;
   localparam int NSLOTS_DEFAULT = 6;

endpackage

// File: rtl/game_sequencer_slot_allocator.sv
// Lowest-index free asteroid slot picker; purely combinational, zero latency.
// No flow control: any_free low means the caller drops the spawn request.
module slot_allocator #(
   parameter int NSLOTS = 6
) (
   input  logic [NSLOTS-1:0] free,
   output logic [NSLOTS-1:0] grant,
   output logic              any_free
);

   // Two's-complement trick isolates the lowest set bit.
   assign grant    = free & (~free + NSLOTS'(1));
   assign any_free = |free;

endmodule

// File: rtl/game_sequencer.sv
// Frame-rate game FSM: spawns/retires asteroid slots, tracks collisions, lives, score.
// All outputs registered, 1-cycle response; no backpressure (spawns drop when slots are full).
module game_sequencer
   import galaga_pkg::*;
#(
   parameter int NSLOTS       = NSLOTS_DEFAULT,
   parameter int SPAWN_FRAMES = 128,
   parameter int HIT_FRAMES   = 60,
   parameter int LIVES        = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_tick,
   input  logic              start,
   input  logic [9:0]        rng_x,
   input  logic              collide,
   input  logic [NSLOTS-1:0] slot_done,
   output logic [NSLOTS-1:0] slot_en,
   output logic [NSLOTS-1:0] slot_load,
   output logic [9:0]        slot_x,
   output logic [1:0]        state,
   output logic [1:0]        lives,
   output logic [15:0]       score,
   output logic              rocket_freeze,
   output logic              flash
);

   localparam int SCW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
   // flash taps bit 3, so the hit counter is never narrower than 4 bits.
   localparam int HCW = ($clog2(HIT_FRAMES) < 4) ? 4 : $clog2(HIT_FRAMES);
   localparam logic [1:0] LIVES_INIT = 2'(LIVES);

   game_state_t       state_q, state_d;
   logic [1:0]        lives_q, lives_d;
   logic [15:0]       score_q, score_d;
   logic [NSLOTS-1:0] slot_en_q, slot_en_d;
   logic [NSLOTS-1:0] slot_load_q, slot_load_d;
   logic [9:0]        slot_x_q, slot_x_d;
   logic              freeze_q, freeze_d;
   logic              flash_q, flash_d;
   logic [SCW-1:0]    spawn_cnt_q, spawn_cnt_d;
   logic [HCW-1:0]    hit_cnt_q, hit_cnt_d;
   logic              hit_seen_q, hit_seen_d;

   logic [NSLOTS-1:0] grant;
   logic              any_free;
   logic [NSLOTS-1:0] retire;
   logic [16:0]       score_sum;
   logic [15:0]       score_sat;

   slot_allocator #(.NSLOTS(NSLOTS)) u_alloc (
      .free     (~slot_en_q),
      .grant    (grant),
      .any_free (any_free)
   );

   assign retire = slot_done & slot_en_q;

   always_comb begin
      score_sum = {1'b0, score_q};
      for (int i = 0; i < NSLOTS; i++) begin
         score_sum = score_sum + 17'(retire[i]);
      end
      score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      score_d     = score_q;
      slot_en_d   = slot_en_q;
      slot_load_d = '0;
      slot_x_d    = slot_x_q;
      spawn_cnt_d = spawn_cnt_q;
      hit_cnt_d   = hit_cnt_q;
      hit_seen_d  = hit_seen_q;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               state_d     = ST_PLAY;
               lives_d     = LIVES_INIT;
               score_d     = '0;
               spawn_cnt_d = '0;
               hit_seen_d  = 1'b0;
               slot_en_d   = '0;
            end
         end
         ST_PLAY: begin
            if (frame_tick && (hit_seen_q || collide)) begin
               slot_en_d  = '0;
               hit_seen_d = 1'b0;
               hit_cnt_d  = '0;
               if (lives_q <= 2'd1) begin
                  state_d = ST_OVER;
                  lives_d = 2'd0;
               end else begin
                  state_d = ST_HIT;
                  lives_d = lives_q - 2'd1;
               end
            end else begin
               hit_seen_d = hit_seen_q | collide;
               slot_en_d  = slot_en_q & ~retire;
               score_d    = score_sat;
               if (frame_tick) begin
                  hit_seen_d = 1'b0;
                  if (spawn_cnt_q == SCW'(SPAWN_FRAMES - 1)) begin
                     spawn_cnt_d = '0;
                     // Grant comes from the registered mask, so a slot retiring now is skipped.
                     if (any_free) begin
                        slot_en_d   = slot_en_d | grant;
                        slot_load_d = grant;
                        slot_x_d    = rng_x;
                     end
                  end else begin
                     spawn_cnt_d = spawn_cnt_q + 1'b1;
                  end
               end
            end
         end
         ST_HIT: begin
            if (frame_tick) begin
               if (hit_cnt_q == HCW'(HIT_FRAMES - 1)) begin
                  state_d     = ST_PLAY;
                  spawn_cnt_d = '0;
                  hit_seen_d  = 1'b0;
                  hit_cnt_d   = '0;
               end else begin
                  hit_cnt_d = hit_cnt_q + 1'b1;
               end
            end
         end
         default: ;
      endcase

      freeze_d = (state_d != ST_PLAY);
      flash_d  = (state_d == ST_HIT) && hit_cnt_d[3];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         lives_q     <= LIVES_INIT;
         score_q     <= '0;
         slot_en_q   <= '0;
         slot_load_q <= '0;
         slot_x_q    <= '0;
         freeze_q    <= 1'b1;
         flash_q     <= 1'b0;
         spawn_cnt_q <= '0;
         hit_cnt_q   <= '0;
         hit_seen_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         score_q     <= score_d;
         slot_en_q   <= slot_en_d;
         slot_load_q <= slot_load_d;
         slot_x_q    <= slot_x_d;
         freeze_q    <= freeze_d;
         flash_q     <= flash_d;
         spawn_cnt_q <= spawn_cnt_d;
         hit_cnt_q   <= hit_cnt_d;
         hit_seen_q  <= hit_seen_d;
      end
   end

   assign state         = state_q;
   assign lives         = lives_q;
   assign score         = score_q;
   assign slot_en       = slot_en_q;
   assign slot_load     = slot_load_q;
   assign slot_x        = slot_x_q;
   assign rocket_freeze = freeze_q;
   assign flash         = flash_q;

endmodule
